// File: rtl/debug_in_pio.sv
// Avalon-MM debug input PIO: synchronises asynchronous inputs, captures edges into a
// write-1-to-clear register and raises a masked level interrupt.
module debug_in_pio #(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic {DISARMED, ARMED} arm_state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr_bits;
  logic [2:0]       arm_cnt;
  arm_state_t       state, state_next;
  logic             wr_en;

  assign sync  = sync_q[SYNC_STAGES-1];
  assign wr_en = chipselect & ~write_n;

  // NOTE: the synchroniser array is a real flop chain, so it is reset like any other
  // register; a reset sync chain guarantees sync and prev start equal at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= sync;
    end
  end

  // Arming sequence lets the chain flush so levels present at reset never look like edges.
  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    state_next = state;
    if (state == DISARMED && arm_cnt == 3'(SYNC_STAGES)) state_next = ARMED;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= DISARMED;
      arm_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == DISARMED) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_comb begin
    edge_hit = '0;
    if (state == ARMED) begin
      case (EDGE_TYPE)
        0:       edge_hit = sync & ~prev;
        1:       edge_hit = ~sync & prev;
        default: edge_hit = sync ^ prev;
      endcase
    end
  end

  assign clr_bits = (wr_en && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

  // A fresh edge overrides a simultaneous clear of the same bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clr_bits) | edge_hit;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = reset_n ? sync : '0;
      3'd2:    readdata[WIDTH-1:0] = irq_mask;
      3'd3:    readdata[WIDTH-1:0] = edge_capture;
      default: readdata = '0;
    endcase
  end

  assign irq = reset_n & (|(edge_capture & irq_mask));

  generate
    if (WIDTH < 32) begin : g_hi
      logic unused_writedata_hi;
      assign unused_writedata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule
